// File: rtl/input_debounce_bank.sv
// Multi-channel input debouncer: per-channel synchroniser, stability counter and
// one-cycle rise/fall strobes on each accepted level change.
module input_debounce_bank #(
    parameter int                  CHANNELS      = 8,
    parameter int                  STABLE_CYCLES = 1000000,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CHANNELS-1:0] RESET_LEVEL   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i,
    output logic [CHANNELS-1:0] o,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_busy
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("input_debounce_bank: CHANNELS must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("input_debounce_bank: STABLE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("input_debounce_bank: SYNC_STAGES must be >= 1");
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] o_q, o_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] s;
    logic                busy;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Any sample matching the current level restarts the count; the terminal
    // count accepts the new level and clears the counter in the same edge.
    always_comb begin
        o_d    = o_q;
        rise_d = '0;
        fall_d = '0;
        busy   = 1'b0;
        for (int n = 0; n < CHANNELS; n++) begin
            cnt_d[n] = '0;
            if (s[n] != o_q[n]) begin
                if (cnt_q[n] == CNT_TERM) begin
                    o_d[n]    = s[n];
                    rise_d[n] = s[n];
                    fall_d[n] = ~s[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_ONE;
                end
            end
            if (cnt_q[n] != '0) begin
                busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_LEVEL;
            end
            for (int n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= '0;
            end
            o_q    <= RESET_LEVEL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o      = o_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_busy = busy;

endmodule

// File: tb/tb_input_debounce_bank.sv
// Bench for input_debounce_bank: a 4-cycle and a 1-cycle debouncer share stimulus;
// a reference model fills per-instance queues that a negedge monitor drains.
module tb_input_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i;
    logic [3:0] o4, r4, f4;
    logic       b4;
    logic [3:0] o1, r1, f1;
    logic       b1;

    always #5 clk = ~clk;

    input_debounce_bank #(
        .CHANNELS(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(4'b0001)
    ) dut4 (
        .clk(clk), .rst(rst), .i(i), .o(o4), .o_rise(r4), .o_fall(f4), .o_busy(b4)
    );

    input_debounce_bank #(
        .CHANNELS(4), .STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(4'b0000)
    ) dut1 (
        .clk(clk), .rst(rst), .i(i), .o(o1), .o_rise(r1), .o_fall(f1), .o_busy(b1)
    );

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic       b;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       em;
    int         total = 0;
    int         bad   = 0;

    logic [3:0] rlv [2];
    int         stm [2];
    logic [3:0] dl  [2][2];
    logic [3:0] mo  [2];
    int         run [2][4];

    initial begin
        rlv[0] = 4'b0001; rlv[1] = 4'b0000;
        stm[0] = 4;       stm[1] = 1;
    end

    // Model: input reaches the filter two edges late; a level is accepted after
    // the configured number of consecutive differing samples.
    task automatic model_edge(input int k, output exp_t e);
        logic [3:0] sv;
        e = '0;
        if (rst) begin
            dl[k][0] = rlv[k];
            dl[k][1] = rlv[k];
            mo[k]    = rlv[k];
            for (int n = 0; n < 4; n++) run[k][n] = 0;
        end else begin
            sv       = dl[k][1];
            dl[k][1] = dl[k][0];
            dl[k][0] = i;
            for (int n = 0; n < 4; n++) begin
                if (sv[n] != mo[k][n]) begin
                    run[k][n] = run[k][n] + 1;
                    if (run[k][n] == stm[k]) begin
                        mo[k][n] = sv[n];
                        if (sv[n]) e.r[n] = 1'b1;
                        else       e.f[n] = 1'b1;
                        run[k][n] = 0;
                    end
                end else begin
                    run[k][n] = 0;
                end
            end
        end
        e.o = mo[k];
        for (int n = 0; n < 4; n++) begin
            if (run[k][n] != 0) e.b = 1'b1;
        end
    endtask

    task automatic cmp(input string name, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got o=%b rise=%b fall=%b busy=%b, want o=%b rise=%b fall=%b busy=%b",
                     name, act.o, act.r, act.f, act.b, exp.o, exp.r, exp.f, exp.b);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            em = q0.pop_front();
            cmp("dut4 model", {o4, r4, f4, b4}, em);
        end
        if (q1.size() > 0) begin
            em = q1.pop_front();
            cmp("dut1 model", {o1, r1, f1, b1}, em);
        end
    end

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge(0, e);
        q0.push_back(e);
        model_edge(1, e);
        q1.push_back(e);
        #1;
    endtask

    task automatic drive(input logic [3:0] ni, input logic nrst);
        i   = ni;
        rst = nrst;
    endtask

    task automatic hold(input logic [3:0] ni, input int n);
        drive(ni, 1'b0);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset o dut4", o4, 4'b0001);
            check("reset o dut1", o1, 4'b0000);
            check("reset strobes", r4 | f4, 4'b0000);
        end

        // release: o[0] of dut4 falls on the sixth edge
        drive(4'b0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) check("o0 before fall", o4, 4'b0001);
            if (c == 6) begin
                check("o0 fallen", o4, 4'b0000);
                check("fall0 pulse", f4, 4'b0001);
            end
        end
        tick();
        check("fall0 single", f4, 4'b0000);

        // i[1] rises: busy edges 3..5, level and strobe at edge 6
        drive(4'b0010, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("busy edge %0d", c), {3'b000, b4},
                  (c >= 3 && c <= 5) ? 4'b0001 : 4'b0000);
            if (c == 2) check("dut1 lag before", o1, 4'b0000);
            if (c == 3) check("dut1 lag 3", o1, 4'b0010);
            if (c == 5) check("o1 before rise", o4, 4'b0000);
            if (c == 6) begin
                check("o1 risen", o4, 4'b0010);
                check("rise1 pulse", r4, 4'b0010);
            end
        end
        hold(4'b0010, 3);

        // short pulse on i[2] is rejected
        hold(4'b0110, 3);
        hold(4'b0010, 8);
        check("glitch rejected", o4, 4'b0010);

        // i[3] chatters then settles high
        for (int c = 0; c < 10; c++) hold({c[0], 3'b010}, 1);
        hold(4'b1010, 8);
        check("chatter settles", o4, 4'b1010);

        // simultaneous rise of i[1] and i[2]
        hold(4'b0000, 8);
        drive(4'b0110, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) check("joint rise", r4, 4'b0110);
        end
        hold(4'b0110, 3);

        // reset mid-count, then i still held
        hold(4'b0111, 4);
        drive(4'b0111, 1'b1);
        tick();
        check("mid reset o", o4, 4'b0001);
        hold(4'b0111, 8);

        // random phase with occasional reset
        for (int b = 0; b < 120; b++) begin
            logic [3:0] ni;
            int         len;
            ni  = i ^ 4'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 31) == 0) begin
                drive(ni, 1'b1);
                tick();
            end
            hold(ni, len);
        end
        hold(i, 10);

        @(negedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL queue drain: got %0d/%0d left want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
